// File: rtl/mcp_tx_queue.sv
// Transmit-domain FIFO feeding a multi-cycle-path CDC send handshake.
// Optional sticky overflow flag: define MCP_TX_QUEUE_OVERFLOW_EN.
module mcp_tx_queue #(
  parameter int width      = 8,
  parameter int depth_log2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [width-1:0]      wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [depth_log2:0]   count,
  input  logic                  flush,
  output logic                  overflow,
  input  logic                  mcp_ready,
  output logic                  mcp_send,
  output logic [width-1:0]      mcp_data
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0] depth_cnt = {1'b1, {depth_log2{1'b0}}};

  logic [depth_log2:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2:0] rd_ptr_q, rd_ptr_d;
  logic [width-1:0]    mem_q [depth];
  logic                push;
  logic                pop;

  // Pointers carry one extra MSB so full and empty stay distinguishable.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == depth_cnt);
  assign empty = (count == '0);

  // Handshake: a word transfers on every cycle mcp_send=1; mcp_send is only
  // raised while mcp_ready=1, the queue is non-empty and no flush is pending.
  assign mcp_send = ~empty & mcp_ready & ~flush;
  assign mcp_data = mem_q[rd_ptr_q[depth_log2-1:0]];

  assign pop  = mcp_send;
  assign push = wr_en & ~full & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[depth_log2-1:0]] <= wr_data;
  end

`ifdef MCP_TX_QUEUE_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && full && !flush) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mcp_tx_queue.sv
// Self-checking bench for mcp_tx_queue against a queue-based reference model.
module tb_mcp_tx_queue;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       mcp_ready = 1'b0;
  logic       full, empty, overflow, mcp_send;
  logic [2:0] count;
  logic [7:0] mcp_data;

  int tests = 0;
  int failed = 0;

  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  logic       last_send = 1'b0;
  int         busy = 0;

  mcp_tx_queue #(.width(8), .depth_log2(2)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .flush(flush),
    .overflow(overflow), .mcp_ready(mcp_ready), .mcp_send(mcp_send),
    .mcp_data(mcp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, check before the rising edge,
  // then advance the reference model at the rising edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic fl, input logic rdy);
    int  n;
    logic snd;
    @(negedge clk);
    wr_en = we; wr_data = wd; flush = fl; mcp_ready = rdy;
    #1;
    n   = exp_q.size();
    snd = (n != 0) && rdy && !fl;
    check("count", 32'(count), 32'(n));
    check("empty", 32'(empty), 32'(n == 0));
    check("full", 32'(full), 32'(n == 4));
    check("mcp_send", 32'(mcp_send), 32'(snd));
    if (snd) check("mcp_data", 32'(mcp_data), 32'(exp_q[0]));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    @(posedge clk);
`ifdef MCP_TX_QUEUE_OVERFLOW_EN
    if (we && n == 4 && !fl) exp_ovf = 1'b1;
`endif
    if (fl) exp_q.delete();
    else begin
      if (snd) void'(exp_q.pop_front());
      if (we && n < 4) exp_q.push_back(wd);
    end
    last_send = snd;
  endtask

  // MCP handshake: after each send, ready drops for a few cycles until acknowledge.
  task automatic mcp_cycle(input logic we, input logic [7:0] wd, input logic fl);
    cycle(we, wd, fl, busy == 0);
    if (last_send) busy = $urandom_range(1, 3);
    else if (busy > 0) busy--;
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 1);

    // Single push with ready held high
    cycle(1, 8'hA5, 0, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Fill while MCP is busy, overflow push, then drain under handshake
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0);
    cycle(1, 8'h05, 0, 0);
    cycle(0, 8'h00, 0, 0);
    busy = 0;
    for (int i = 0; i < 20; i++) mcp_cycle(0, 8'h00, 0);

    // Steady state at count 2 with push and pop every cycle, past two wraps
    cycle(1, 8'h10, 0, 0);
    cycle(1, 8'h11, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 8'($urandom_range(0, 255)), 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1);

    // Flush with simultaneous push and ready
    for (int i = 0; i < 3; i++) cycle(1, 8'(8'h20 + i), 0, 0);
    cycle(1, 8'h77, 1, 1);
    cycle(0, 8'h00, 0, 1);

    // Asynchronous reset between edges with two words queued
    cycle(1, 8'h31, 0, 0);
    cycle(1, 8'h32, 0, 0);
    @(negedge clk);
    wr_en = 1'b0; mcp_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_send", 32'(mcp_send), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1);

    // Randomized traffic
    busy = 0;
    for (int i = 0; i < 300; i++) begin
      if (i < 150)
        mcp_cycle($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 31) == 0);
      else
        cycle($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
              $urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mcp_tx_queue.md
# mcp_tx_queue

Small synchronous FIFO in the transmit-clock domain that feeds a multi-cycle-path (MCP) clock-domain-crossing block. Producers push words at up to one per cycle. The queue drains them into the MCP's send handshake one word per MCP round trip. It guarantees that a send is only requested when the MCP reports ready, and absorbs bursts that the MCP's feedback handshake would otherwise drop.

## Interface
Parameters:
- `width`, default 8: data word width in bits.
- `depth_log2`, default 2: log2 of the queue depth; depth = 2^`depth_log2`, minimum 1.

Ports:
- `clk`, in, 1: the MCP transmit-domain clock.
- `reset_n`, in, 1: one clock; reset is asynchronous and active-low.
- `wr_en`, in, 1: push `wr_data` this cycle.
- `wr_data`, in, `width`: word to push.
- `full`, out, 1: queue holds depth words.
- `empty`, out, 1: queue holds 0 words.
- `count`, out, `depth_log2`+1: current occupancy, 0..depth.
- `flush`, in, 1: synchronously discard all queued words.
- `overflow`, out, 1: sticky flag, set by a push while full.
- `mcp_ready`, in, 1: MCP transmit-side ready; may be combinational from the MCP's acknowledge.
- `mcp_send`, out, 1: single-cycle send request to the MCP.
- `mcp_data`, out, `width`: word offered to the MCP.

## Operation
- Storage is a circular buffer with read and write pointers of `depth_log2`+1 bits. The extra MSB distinguishes full from empty. Pointers wrap modulo 2·depth; the buffer index is the low `depth_log2` bits.
- `mcp_data` = buffer[read index], combinational. When `empty`=1 its value is don't-care.
- `mcp_send` = ~`empty` & `mcp_ready` & ~`flush`, combinational. It is never asserted while `mcp_ready`=0, because the MCP marks itself busy on any send.
- Pop: occurs in every cycle with `mcp_send`=1; the read pointer increments at the clock edge.
- Push: `wr_en` & ~`full` & ~`flush` writes `wr_data` at the write index and increments the write pointer.
- A push while full is dropped and the queue is unchanged. This holds even if a pop occurs in the same cycle, because `full` is evaluated before the edge.
- Simultaneous push and pop when neither full nor empty: both pointers advance and `count` is unchanged.
- Push into an empty queue is not bypassed. The word becomes visible on `mcp_data` on the next cycle.
- Flush: both pointers are set to 0 at the edge. A `wr_en` in the flush cycle is ignored, and `mcp_send` is forced to 0. `overflow` is not cleared by flush.
- `count` = write pointer − read pointer, modulo 2·depth.
- `full` = (`count` == depth); `empty` = (`count` == 0).

## Timing
- Reset values (asynchronous, on `reset_n`=0): pointers 0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `mcp_send`=0. Buffer contents are not reset.
- Reset may assert mid-operation. Queued words are discarded; the MCP's own reset is responsible for any in-flight word.
- Latency from a push into an empty queue to the first `mcp_send` is 1 cycle, provided `mcp_ready`=1.
- Sustained drain rate is one word per MCP handshake: send, then ready low, then acknowledge, then ready high. Each `mcp_send` pulse lasts exactly 1 cycle per word.
- `full`, `empty` and `count` are registered-derived and update on the edge after a push or pop.

## Configuration
- `MCP_TX_QUEUE_OVERFLOW_EN` defined:
  - `overflow` is a register, set at the edge following any cycle with `wr_en`=1, `full`=1 and `flush`=0.
  - It stays set until `reset_n` asserts.
- `MCP_TX_QUEUE_OVERFLOW_EN` undefined:
  - `overflow` is tied to 0 and no flag register exists.
  - Dropped pushes are still dropped.

## Test plan
- Reset release with idle inputs -> `empty`=1, `full`=0, `count`=0, `mcp_send`=0, `overflow`=0.
- Push 0xA5 with `mcp_ready`=1 held -> `mcp_send` pulses 1 cycle later with `mcp_data`=0xA5, and `empty` returns to 1.
- `mcp_ready`=0; push 0x01..0x04 (depth 4) -> `full`=1 and `count`=4. A fifth push of 0x05 is dropped, and `overflow`=1 when the macro is defined, 0 when undefined. Then release `mcp_ready` with the bench modelling the MCP handshake -> sends arrive in order 0x01..0x04, each send only while ready, and no 0x05 is ever sent.
- Queue at `count`=2 with `mcp_ready`=1; push and pop in the same cycle -> `count` remains 2 and order is preserved. Continue until the pointers wrap twice -> no data corruption.
- `count`=3; assert `flush` together with `wr_en` and `mcp_ready`=1 -> `mcp_send`=0 in that cycle, and the next cycle shows `count`=0 and `empty`=1. A sticky `overflow` is retained.
- Queue holding 2 words; assert `reset_n`=0 asynchronously between edges -> outputs return to their reset values immediately. After release, `mcp_send` stays 0 until a new push.
